bootrom_wb_reader: RTL and testbench
====================================

Name: bootrom_wb_reader

Overview:
- Wishbone slave that serves CPU reads from the 512x16 boot ROM.
- Drives the ROM's synchronous read port: address, read reset, sampled data.
- Returns the data with a single-cycle ack. Writes are acked but discarded, and a write-error pulse is flagged.
- Implements the M9312-style power-up vector overlay: after reset, the first two vector fetches are redirected to a fixed ROM window.
- Sits between the bus fabric and the ROM macro.

Parameters:
- ADDR_WIDTH, 9, ROM word-address width (depth = 2**ADDR_WIDTH).
- VEC_BASE, 9'h0FE, ROM word address of the power-up vector pair (PC at VEC_BASE, PSW at VEC_BASE+1).
- VEC_COUNT, 2, number of vector fetches served from the overlay before it disarms.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
- wb_adr_i  in  ADDR_WIDTH  word address (byte address bits [ADDR_WIDTH:1]).
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe for this slave.
- wb_we_i  in  1  write enable.
- wb_dat_o  out  16  read data.
- wb_ack_o  out  1  cycle acknowledge.
- vec_i  in  1  current cycle is a power-up vector fetch.
- rom_addr_o  out  ADDR_WIDTH  ROM address.
- rom_rst_o  out  1  ROM synchronous output reset.
- rom_data_i  in  16  ROM output, valid one clock after the address edge.
- vec_armed_o  out  1  overlay still active.
- wr_err_o  out  1  one-cycle pulse on an attempted ROM write.

Behaviour:
- Reset (wb_rst_n_i low, asynchronous):
  - State IDLE.
  - wb_ack_o=0, wb_dat_o=0, rom_addr_o=0, rom_rst_o=1, wr_err_o=0.
  - vec_armed_o=1, vec counter=0.
- FSM states: IDLE, ADDR, DATA, ACK, WAIT.
- IDLE:
  - rom_rst_o=1 (ROM output held at zero).
  - On wb_cyc_i&wb_stb_i:
    - Read (wb_we_i=0): latch rom_addr_o. The address is VEC_BASE+vec counter when vec_i&vec_armed_o, else wb_adr_i. Then go to ADDR.
    - Write (wb_we_i=1): pulse wr_err_o, go directly to ACK. wb_dat_o is unchanged.
- ADDR:
  - rom_rst_o=0; the ROM samples the address at the end of this cycle. Go to DATA.
- DATA:
  - Capture rom_data_i into wb_dat_o. Go to ACK.
  - If the read was an overlay fetch, increment the vec counter; when it reaches VEC_COUNT, clear vec_armed_o.
- ACK:
  - wb_ack_o=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Stay until wb_stb_i=0, then go to IDLE.
  - Back-to-back strobes without deassertion are not re-acked.
- Read latency: ack asserted 3 clocks after the first clock where stb is sampled high.
- Abort: if wb_cyc_i drops in ADDR or DATA, go to IDLE.
  - No ack is issued and wb_dat_o is not updated.
  - The vec counter is not incremented.
- Overlay disarm:
  - The overlay is only re-armed by reset.
  - A vector fetch with vec_armed_o=0 reads wb_adr_i normally.
  - vec_i on a write is ignored.
- Address wrap: rom_addr_o width is ADDR_WIDTH. VEC_BASE+counter wraps modulo 2**ADDR_WIDTH.
- wb_dat_o holds its last value until the next completed read.
- Reset mid-cycle: immediate return to reset values; a pending ack is lost.

Decomposition:
- Shared package (dvk_bootrom_pkg):
  - FSM state enum (3-bit encoding).
  - Default VEC_BASE/VEC_COUNT.
  - ROM data width constant, 16.
- One sub-module is natural: bootrom_vec_overlay. It holds the vec counter and armed flag, and does the address mux.
- The FSM stays in the top module.

Test Plan:
- Read with ROM model word[0x010]=0x1234 (wb_adr_i=0x010, vec_i=0): wb_ack_o high on clock 3 after stb, wb_dat_o=0x1234, rom_addr_o=0x010.
- After reset, two reads with vec_i=1 and ROM[0x0FE]=0x0173, ROM[0x0FF]=0x0340: data 0x0173 then 0x0340, vec_armed_o falls after the second read. A third vec_i read at wb_adr_i=0x012 returns ROM[0x012].
- Write at 0x020, data ignored: wr_err_o one-cycle pulse, ack 1 clock after stb, wb_dat_o unchanged, no ROM address update.
- wb_cyc_i dropped in DATA during the first vector fetch: no ack, wb_dat_o unchanged, vec_armed_o stays 1. The next vector read still returns ROM[0x0FE].
- Strobe held high for 10 clocks: exactly one ack. Reset asserted in ADDR: wb_ack_o=0 and rom_rst_o=1 immediately, vec_armed_o=1.

Source files
------------

// File: rtl/dvk_bootrom_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dvk_bootrom_pkg : shared types and defaults for the boot ROM port |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package dvk_bootrom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_ACK  = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  localparam int unsigned DEF_VEC_BASE  = 32'h0FE;
  localparam int unsigned DEF_VEC_COUNT = 2;
  localparam int unsigned ROM_DW        = 16;

endpackage
`default_nettype wire

// File: rtl/bootrom_vec_overlay.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bootrom_vec_overlay : power-up vector redirect and address mux   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module bootrom_vec_overlay
  import dvk_bootrom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned VEC_BASE   = DEF_VEC_BASE,
  parameter int unsigned VEC_COUNT  = DEF_VEC_COUNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vec,
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic                  start,
  input  logic                  commit,
  output logic [ADDR_WIDTH-1:0] sel_adr,
  output logic                  armed
);

  localparam int unsigned CW = $clog2(VEC_COUNT + 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(VEC_BASE);

  logic [CW-1:0] cnt;
  logic          fetch_vec;
  logic          hit;

  assign hit     = vec & armed;
  // Sum is truncated to ADDR_WIDTH so the window wraps around the ROM.
  assign sel_adr = hit ? (BASE + ADDR_WIDTH'(cnt)) : adr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      armed     <= 1'b1;
      fetch_vec <= 1'b0;
    end else begin
      if (start) begin
        fetch_vec <= hit;
      end
      if (commit && fetch_vec) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(VEC_COUNT - 1)) begin
          armed <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bootrom_wb_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bootrom_wb_reader : Wishbone read slave for the 512x16 boot ROM   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module bootrom_wb_reader
  import dvk_bootrom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned VEC_BASE   = DEF_VEC_BASE,
  parameter int unsigned VEC_COUNT  = DEF_VEC_COUNT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  output logic [ROM_DW-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  input  logic                  vec_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  rom_rst_o,
  input  logic [ROM_DW-1:0]     rom_data_i,
  output logic                  vec_armed_o,
  output logic                  wr_err_o
);

  state_t                state;
  state_t                next_state;
  logic                  req;
  logic                  rd_start;
  logic                  wr_start;
  logic                  rd_done;
  logic [ADDR_WIDTH-1:0] sel_adr;

  assign req      = wb_cyc_i & wb_stb_i;
  assign rd_start = (state == ST_IDLE) & req & ~wb_we_i;
  assign wr_start = (state == ST_IDLE) & req & wb_we_i;
  // A cycle dropped in DATA must neither update the data nor count a vector.
  assign rd_done  = (state == ST_DATA) & wb_cyc_i;

  bootrom_vec_overlay #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .VEC_BASE   (VEC_BASE),
    .VEC_COUNT  (VEC_COUNT)
  ) u_overlay (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .vec     (vec_i),
    .adr     (wb_adr_i),
    .start   (rd_start),
    .commit  (rd_done),
    .sel_adr (sel_adr),
    .armed   (vec_armed_o)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    wb_ack_o   = 1'b0;
    rom_rst_o  = 1'b1;
    case (state)
      ST_IDLE: begin
        if (req) begin
          next_state = wb_we_i ? ST_ACK : ST_ADDR;
        end
      end
      ST_ADDR: begin
        rom_rst_o  = 1'b0;
        next_state = wb_cyc_i ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        next_state = wb_cyc_i ? ST_ACK : ST_IDLE;
      end
      ST_ACK: begin
        wb_ack_o   = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (!wb_stb_i) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rom_addr_o <= '0;
      wb_dat_o   <= '0;
      wr_err_o   <= 1'b0;
    end else begin
      wr_err_o <= wr_start;
      if (rd_start) begin
        rom_addr_o <= sel_adr;
      end
      if (rd_done) begin
        wb_dat_o <= rom_data_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bootrom_wb_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bootrom_wb_reader : directed self-checking bench               |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_bootrom_wb_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        vec;
  logic [15:0] dat;
  logic        ack;
  logic [8:0]  rom_addr;
  logic        rom_rst;
  logic [15:0] rom_q;
  logic        armed;
  logic        wr_err;

  logic [15:0] mem [0:511];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  bootrom_wb_reader dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .wb_adr_i    (adr),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_we_i     (we),
    .wb_dat_o    (dat),
    .wb_ack_o    (ack),
    .vec_i       (vec),
    .rom_addr_o  (rom_addr),
    .rom_rst_o   (rom_rst),
    .rom_data_i  (rom_q),
    .vec_armed_o (armed),
    .wr_err_o    (wr_err)
  );

  // Synchronous ROM with output reset.
  always @(posedge clk) begin
    if (rom_rst) rom_q <= 16'h0000;
    else         rom_q <= mem[rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full read; stb sampled at the first edge, ack visible after the third.
  task automatic do_read(input string tag, input logic [8:0] a, input logic v,
                         input logic [8:0] exp_addr, input logic [15:0] exp_dat);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; vec = v;
    tick();
    check({tag, "_addr"}, rom_addr, exp_addr);
    check({tag, "_romrst"}, rom_rst, 0);
    check({tag, "_ack_e1"}, ack, 0);
    tick();
    check({tag, "_ack_e2"}, ack, 0);
    tick();
    check({tag, "_ack"}, ack, 1);
    check({tag, "_dat"}, dat, exp_dat);
    cyc = 1'b0; stb = 1'b0; vec = 1'b0;
    tick();
    check({tag, "_ack_off"}, ack, 0);
    tick();
  endtask

  initial begin
    int acks;
    for (int i = 0; i < 512; i++) mem[i] = 16'hA500 ^ 16'(i);
    mem[9'h010] = 16'h1234;
    mem[9'h012] = 16'h5A5A;
    mem[9'h0FE] = 16'h0173;
    mem[9'h0FF] = 16'h0340;

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; vec = 1'b0;
    tick(); tick();
    check("rst_ack", ack, 0);
    check("rst_dat", dat, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_romrst", rom_rst, 1);
    check("rst_wrerr", wr_err, 0);
    check("rst_armed", armed, 1);
    rst_n = 1'b1;
    tick();

    do_read("rd010", 9'h010, 1'b0, 9'h010, 16'h1234);
    check("rd010_armed", armed, 1);

    // Abort in DATA during the first vector fetch.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 9'h030; vec = 1'b1;
    tick();
    check("abt_addr", rom_addr, 9'h0FE);
    tick();
    cyc = 1'b0; stb = 1'b0; vec = 1'b0;
    tick();
    check("abt_ack", ack, 0);
    tick();
    check("abt_ack2", ack, 0);
    check("abt_dat", dat, 16'h1234);
    check("abt_armed", armed, 1);

    do_read("vec0", 9'h030, 1'b1, 9'h0FE, 16'h0173);
    check("vec0_armed", armed, 1);
    do_read("vec1", 9'h031, 1'b1, 9'h0FF, 16'h0340);
    check("vec1_armed", armed, 0);
    do_read("vec2", 9'h012, 1'b1, 9'h012, 16'h5A5A);

    // Write: acked one edge after stb, discarded, error pulse.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 9'h020; vec = 1'b1;
    tick();
    check("wr_ack", ack, 1);
    check("wr_err", wr_err, 1);
    check("wr_dat", dat, 16'h5A5A);
    check("wr_addr", rom_addr, 9'h012);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; vec = 1'b0;
    tick();
    check("wr_ack_off", ack, 0);
    check("wr_err_off", wr_err, 0);
    check("wr_armed", armed, 0);
    tick();

    // Strobe held for 10 clocks gets exactly one ack.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 9'h010; vec = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack) acks++;
    end
    check("hold_acks", acks, 1);
    check("hold_dat", dat, 16'h1234);
    cyc = 1'b0; stb = 1'b0;
    tick(); tick();

    // Asynchronous reset while in ADDR.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 9'h012; vec = 1'b0;
    tick();
    check("rstaddr_pre", rom_rst, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rstaddr_ack", ack, 0);
    check("rstaddr_romrst", rom_rst, 1);
    check("rstaddr_armed", armed, 1);
    check("rstaddr_dat", dat, 0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_read("rearm", 9'h040, 1'b1, 9'h0FE, 16'h0173);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
